// File: rtl/flash_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a single flash bus engine.
// One transaction in flight at a time; every output is driven from a flop.
module flash_bus_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd200
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic       req0,
    input  logic       req1,
    input  logic       flow0,
    input  logic       flow1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       done0,
    output logic       done1,
    output logic       err0,
    output logic       err1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic       fb_start,
    output logic       fb_flow,
    output logic [7:0] fb_addr,
    output logic [7:0] fb_wdata,
    input  logic       fb_done,
    input  logic [7:0] fb_rdata,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       owner;
    logic       last_grant;
    logic [7:0] wait_cnt;
    logic       grant_valid;
    logic       grant_idx;
    logic       finish;
    logic       wait_expired;

    // The cycle being counted now is wait cycle wait_cnt+1.
    assign wait_expired = ({1'b0, wait_cnt} + 9'd1) == {1'b0, TIMEOUT};

    // NOTE: sequential state uses <= so every flop samples pre-edge values,
    // independent of the order in which always blocks are evaluated.
    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal gets a default before the case, so no path leaves
    // a combinational output unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        grant_valid = 1'b0;
        grant_idx   = 1'b0;
        finish      = 1'b0;
        case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    grant_valid = 1'b1;
                    grant_idx   = (req0 && req1) ? ~last_grant : req1;
                    state_next  = S_ISSUE;
                end
            end
            S_ISSUE: state_next = S_WAIT;
            S_WAIT: begin
                if (fb_done || wait_expired) begin
                    finish     = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            wait_cnt   <= 8'h00;
            fb_start   <= 1'b0;
            fb_flow    <= 1'b0;
            fb_addr    <= 8'h00;
            fb_wdata   <= 8'h00;
            busy       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            rdata0     <= 8'h00;
            rdata1     <= 8'h00;
        end else begin
            fb_start <= (state_next == S_ISSUE);
            busy     <= (state_next != S_IDLE);
            done0    <= finish && !owner;
            done1    <= finish && owner;
            // fb_done beats a coincident timeout, so err only when it is absent.
            err0     <= finish && !owner && !fb_done;
            err1     <= finish && owner && !fb_done;

            if (grant_valid) begin
                owner      <= grant_idx;
                last_grant <= grant_idx;
                fb_flow    <= grant_idx ? flow1 : flow0;
                fb_addr    <= grant_idx ? addr1 : addr0;
                fb_wdata   <= grant_idx ? wdata1 : wdata0;
            end

            if (state == S_ISSUE) begin
                wait_cnt <= 8'h00;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            if (finish && !owner) begin
                rdata0 <= fb_done ? fb_rdata : 8'h00;
            end
            if (finish && owner) begin
                rdata1 <= fb_done ? fb_rdata : 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// Bench for flash_bus_arbiter: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_flash_bus_arbiter;

    localparam int TO = 10;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, flow0 = 1'b0, flow1 = 1'b0;
    logic [7:0] addr0 = 8'h00, addr1 = 8'h00, wdata0 = 8'h00, wdata1 = 8'h00;
    logic       fb_done = 1'b0;
    logic [7:0] fb_rdata = 8'h00;
    logic       done0, done1, err0, err1, fb_start, fb_flow, busy;
    logic [7:0] rdata0, rdata1, fb_addr, fb_wdata;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    flash_bus_arbiter #(.TIMEOUT(8'(TO))) dut (
        .CLK_50MHZ(clk), .RST(RST),
        .req0(req0), .req1(req1), .flow0(flow0), .flow1(flow1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1),
        .fb_start(fb_start), .fb_flow(fb_flow), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
        .fb_done(fb_done), .fb_rdata(fb_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: age counts cycles since grant (1 = start cycle,
    // 2..TO+1 = waiting cycles); m_resp marks the single response cycle.
    int         m_age = 0;
    bit         m_resp = 1'b0;
    bit         m_owner = 1'b0;
    bit         m_last = 1'b1;
    logic       e_busy = 0, e_start = 0, e_flow = 0;
    logic [7:0] e_addr = 0, e_wdata = 0, e_rdata0 = 0, e_rdata1 = 0;
    logic       e_done0 = 0, e_done1 = 0, e_err0 = 0, e_err1 = 0;

    always @(posedge clk) begin
        if (RST) begin
            m_age = 0; m_resp = 0; m_owner = 0; m_last = 1;
            e_start = 0; e_flow = 0; e_addr = 0; e_wdata = 0;
            e_rdata0 = 0; e_rdata1 = 0;
            e_done0 = 0; e_done1 = 0; e_err0 = 0; e_err1 = 0;
        end else begin
            e_start = 0; e_done0 = 0; e_done1 = 0; e_err0 = 0; e_err1 = 0;
            if (m_resp) begin
                m_resp = 0;
                m_age  = 0;
            end else if (m_age == 0) begin
                if (req0 || req1) begin
                    m_owner = (req0 && req1) ? !m_last : req1;
                    m_last  = m_owner;
                    e_flow  = m_owner ? flow1 : flow0;
                    e_addr  = m_owner ? addr1 : addr0;
                    e_wdata = m_owner ? wdata1 : wdata0;
                    e_start = 1;
                    m_age   = 1;
                end
            end else if (m_age >= 2 && (fb_done || (m_age - 1) >= TO)) begin
                m_resp = 1;
                if (m_owner) begin
                    e_done1 = 1; e_err1 = !fb_done; e_rdata1 = fb_done ? fb_rdata : 8'h00;
                end else begin
                    e_done0 = 1; e_err0 = !fb_done; e_rdata0 = fb_done ? fb_rdata : 8'h00;
                end
            end else begin
                m_age++;
            end
        end
        e_busy = (m_age != 0);
    end

    wire [38:0] dut_vec = {busy, fb_start, fb_flow, fb_addr, fb_wdata,
                           done0, done1, err0, err1, rdata0, rdata1};
    wire [38:0] exp_vec = {e_busy, e_start, e_flow, e_addr, e_wdata,
                           e_done0, e_done1, e_err0, e_err1, e_rdata0, e_rdata1};

    always @(negedge clk) begin
        if (cmp_en) check("cycle_outputs", 64'(dut_vec), 64'(exp_vec));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (!fb_start && n < 12) begin
            tick();
            n++;
        end
        check(name, 64'(fb_start), 64'd1);
    endtask

    int cd = 0;
    bit drop0 = 0, drop1 = 0;

    initial begin
        logic [7:0] rr_addr [4];
        int n;
        rr_addr = '{8'hA0, 8'hB1, 8'hA0, 8'hB1};

        // Reset state
        tick(); tick();
        cmp_en = 1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_fb", 64'({fb_start, fb_flow, fb_addr, fb_wdata}), 64'd0);
        check("reset_resp", 64'({done0, done1, err0, err1, rdata0, rdata1}), 64'd0);
        RST = 0;

        // Write from requester 0, fb_done three cycles after fb_start
        req0 = 1; flow0 = 1; addr0 = 8'h12; wdata0 = 8'hA5; fb_rdata = 8'h77;
        tick();
        check("wr_issue", 64'({fb_start, fb_flow, fb_addr, fb_wdata, busy}), 64'({1'b1, 1'b1, 8'h12, 8'hA5, 1'b1}));
        tick();
        check("wr_start_once", 64'(fb_start), 64'd0);
        tick(); tick();
        fb_done = 1;
        tick();
        fb_done = 0;
        check("wr_done", 64'({done0, done1, err0}), 64'b100);
        tick();
        req0 = 0;
        check("wr_done_once", 64'({done0, busy}), 64'd0);

        // Read from requester 1
        req1 = 1; flow1 = 0; addr1 = 8'h40;
        tick();
        check("rd_issue", 64'({fb_flow, fb_addr}), 64'({1'b0, 8'h40}));
        tick();
        fb_done = 1; fb_rdata = 8'h3C;
        tick();
        fb_done = 0;
        check("rd_done", 64'({done1, err1, rdata1, rdata0}), 64'({1'b1, 1'b0, 8'h3C, 8'h77}));
        check("model_rdata1", 64'(e_rdata1), 64'h3C);
        tick();
        req1 = 0;

        // Both held: round-robin order 0,1,0,1
        addr0 = 8'hA0; addr1 = 8'hB1; req0 = 1; req1 = 1;
        for (int i = 0; i < 4; i++) begin
            wait_start("rr_start");
            check("rr_grant", 64'(fb_addr), 64'(rr_addr[i]));
            tick();
            fb_done = 1;
            tick();
            fb_done = 0;
            check("rr_done", 64'({done0, done1}), (i % 2 == 0) ? 64'b10 : 64'b01);
            tick();
        end
        req0 = 0; req1 = 0;
        tick();

        // Timeout: no fb_done, TO waiting cycles then response with err
        req0 = 1; flow0 = 0; addr0 = 8'h55;
        wait_start("to_start");
        n = 0;
        while (!done0 && n < 30) begin
            tick();
            n++;
        end
        check("to_latency", 64'(n), 64'(TO + 1));
        check("to_err", 64'({err0, rdata0}), 64'({1'b1, 8'h00}));
        check("model_to_err", 64'(e_err0), 64'd1);
        tick();
        addr0 = 8'h66;
        wait_start("after_to_start");
        check("after_to_addr", 64'(fb_addr), 64'h66);
        tick();
        fb_done = 1; fb_rdata = 8'h5A;
        tick();
        fb_done = 0;
        check("after_to_done", 64'({done0, err0, rdata0}), 64'({1'b1, 1'b0, 8'h5A}));
        tick();
        req0 = 0;

        // Reset during waiting aborts the transaction
        req0 = 1; addr0 = 8'h21;
        wait_start("abort_start");
        tick(); tick();
        RST = 1; req0 = 0;
        tick();
        RST = 0;
        check("abort_idle", 64'({busy, fb_start, fb_addr}), 64'd0);
        fb_done = 1;
        tick();
        fb_done = 0;
        check("abort_no_done", 64'({busy, done0, done1}), 64'd0);
        tick();
        check("abort_no_done2", 64'({busy, done0, done1}), 64'd0);
        req0 = 1; addr0 = 8'h99;
        wait_start("fresh_start");
        check("fresh_addr", 64'(fb_addr), 64'h99);
        tick();
        fb_done = 1;
        tick();
        fb_done = 0;
        check("fresh_done", 64'(done0), 64'd1);
        tick();
        req0 = 0;

        // Stray fb_done while idle
        tick();
        fb_done = 1;
        tick();
        fb_done = 0;
        check("stray_idle", 64'({busy, done0, done1, err0, err1}), 64'd0);
        tick();
        check("stray_still_idle", 64'({busy, fb_start}), 64'd0);

        // Randomized traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            if (drop0) begin
                req0 = 0; drop0 = 0;
            end else if (!req0 && $urandom_range(0, 3) == 0) begin
                req0 = 1; flow0 = 1'($urandom_range(0, 1));
                addr0 = 8'($urandom); wdata0 = 8'($urandom);
            end else if (req0 && $urandom_range(0, 63) == 0) begin
                req0 = 0;
            end
            if (done0) drop0 = 1;
            if (drop1) begin
                req1 = 0; drop1 = 0;
            end else if (!req1 && $urandom_range(0, 3) == 0) begin
                req1 = 1; flow1 = 1'($urandom_range(0, 1));
                addr1 = 8'($urandom); wdata1 = 8'($urandom);
            end else if (req1 && $urandom_range(0, 63) == 0) begin
                req1 = 0;
            end
            if (done1) drop1 = 1;

            fb_done = 0;
            if (fb_start) begin
                cd = int'($urandom_range(1, TO + 2));
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    fb_done = 1; fb_rdata = 8'($urandom);
                end
            end else if ($urandom_range(0, 49) == 0) begin
                fb_done = 1; fb_rdata = 8'($urandom);
            end
            RST = ($urandom_range(0, 299) == 0);
            if (RST) cd = 0;
        end
        RST = 0; req0 = 0; req1 = 0; fb_done = 0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
